// File: rtl/gpu_write_arbiter_if.sv
// Bundles the two requester ports, the graphics-processor FIFO handshake
// and the status flag of gpu_write_arbiter into one connection.
// master: the side that drives requests and FIFO status (system / bench).
// slave : the arbiter itself.
interface gpu_write_arbiter_if;
  // Requester 0: game-logic instruction words
  logic        req0_valid;
  logic [31:0] req0_data_a;
  logic [31:0] req0_data_b;
  logic        req0_ready;
  // Requester 1: frame-synchronous commands
  logic        req1_valid;
  logic [31:0] req1_data_a;
  logic [31:0] req1_data_b;
  logic        req1_ready;
  // Graphics-processor side
  logic        screen_export;
  logic        wrfull_export;
  logic [31:0] data_a_export;
  logic [31:0] data_b_export;
  logic        wrreg_export;
  // Status
  logic        busy;

  modport master (
    output req0_valid, req0_data_a, req0_data_b,
    output req1_valid, req1_data_a, req1_data_b,
    output screen_export, wrfull_export,
    input  req0_ready, req1_ready,
    input  data_a_export, data_b_export, wrreg_export, busy
  );

  modport slave (
    input  req0_valid, req0_data_a, req0_data_b,
    input  req1_valid, req1_data_a, req1_data_b,
    input  screen_export, wrfull_export,
    output req0_ready, req1_ready,
    output data_a_export, data_b_export, wrreg_export, busy
  );
endinterface

// File: rtl/gpu_write_arbiter.sv
// gpu_write_arbiter: merges two instruction sources into the graphics
// processor's instruction FIFO. One instruction at a time is latched, held
// on the data lines for SETTLE_CYCLES cycles (longer while the FIFO is
// full), written with a single-cycle strobe, then held for one more cycle.
// Requester 1 only competes while the end-of-frame flag is high.
module gpu_write_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1,   // 1..15
  parameter bit          FIXED_PRIO    = 1'b0 // 1: requester 0 always wins
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  gpu_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Counter value on the last settle cycle
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;      // requester granted by the last transfer
  logic [31:0] data_a_q, data_a_d;
  logic [31:0] data_b_q, data_b_d;
  logic        wrreg_q, wrreg_d;

  logic        elig0_s, elig1_s;
  logic        grant0_s, grant1_s;
  logic        rdy0_s, rdy1_s;

  // Eligibility, arbitration and the combinational ready outputs
  always_comb begin
    elig0_s = bus.req0_valid;
    elig1_s = bus.req1_valid & bus.screen_export;
    if (FIXED_PRIO) begin
      grant0_s = elig0_s;
      grant1_s = elig1_s & ~elig0_s;
    end else begin
      // On a tie the requester that did not win last time is served
      grant0_s = elig0_s & (~elig1_s | last_q);
      grant1_s = elig1_s & (~elig0_s | ~last_q);
    end
    // Ready is only offered from IDLE and never while reset is held
    rdy0_s = reset_reset_n & (state_q == ST_IDLE) & grant0_s;
    rdy1_s = reset_reset_n & (state_q == ST_IDLE) & grant1_s;
  end

  // Next-state logic: accept, settle, strobe once, hold, release
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    wrreg_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rdy implies valid, so ready high is the transfer itself
        if (rdy0_s) begin
          data_a_d = bus.req0_data_a;
          data_b_d = bus.req0_data_b;
          last_d   = 1'b0;
          cnt_d    = 4'd0;
          state_d  = ST_SETUP;
        end else if (rdy1_s) begin
          data_a_d = bus.req1_data_a;
          data_b_d = bus.req1_data_b;
          last_d   = 1'b1;
          cnt_d    = 4'd0;
          state_d  = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          // Counter stays saturated while the FIFO reports full
          if (!bus.wrfull_export) begin
            state_d = ST_STROBE;
            wrreg_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_STROBE: begin
        // Write is committed; FIFO full is no longer looked at
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;   // requester 0 wins the first tie
      data_a_q <= 32'd0;
      data_b_q <= 32'd0;
      wrreg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      wrreg_q  <= wrreg_d;
    end
  end

  assign bus.req0_ready    = rdy0_s;
  assign bus.req1_ready    = rdy1_s;
  assign bus.data_a_export = data_a_q;
  assign bus.data_b_export = data_b_q;
  assign bus.wrreg_export  = wrreg_q;
  assign bus.busy          = reset_reset_n & (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpu_write_arbiter.sv
// Bench for gpu_write_arbiter: two instances (round-robin, settle 1 and
// fixed priority, settle 3) share one directed stimulus. A timestamp model
// predicts every output each cycle; directed checks pin grant order,
// latency and spacing with hand-computed numbers.
module tb_gpu_write_arbiter;

  localparam int SET0 = 1;
  localparam int SET1 = 3;
  localparam bit FP0  = 1'b0;
  localparam bit FP1  = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] r0a = 32'd0, r0b = 32'd0, r1a = 32'd0, r1b = 32'd0;
  logic        screen = 1'b0, wrfull = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  gpu_write_arbiter_if bus0 ();
  gpu_write_arbiter_if bus1 ();

  assign bus0.req0_valid = req0_valid;  assign bus1.req0_valid = req0_valid;
  assign bus0.req0_data_a = r0a;        assign bus1.req0_data_a = r0a;
  assign bus0.req0_data_b = r0b;        assign bus1.req0_data_b = r0b;
  assign bus0.req1_valid = req1_valid;  assign bus1.req1_valid = req1_valid;
  assign bus0.req1_data_a = r1a;        assign bus1.req1_data_a = r1a;
  assign bus0.req1_data_b = r1b;        assign bus1.req1_data_b = r1b;
  assign bus0.screen_export = screen;   assign bus1.screen_export = screen;
  assign bus0.wrfull_export = wrfull;   assign bus1.wrfull_export = wrfull;

  gpu_write_arbiter #(.SETTLE_CYCLES(SET0), .FIXED_PRIO(FP0)) u_rr (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(bus0));
  gpu_write_arbiter #(.SETTLE_CYCLES(SET1), .FIXED_PRIO(FP1)) u_fp (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Model state per instance: busy flag, transfer cycle, strobe cycle
  bit          m_busy [2] = '{1'b0, 1'b0};
  int          m_t    [2] = '{0, 0};
  int          m_strb [2] = '{-1, -1};
  bit          m_last [2] = '{1'b1, 1'b1};
  logic [31:0] m_a    [2] = '{32'd0, 32'd0};
  logic [31:0] m_b    [2] = '{32'd0, 32'd0};

  // Event logs taken from the DUT outputs
  int g0_who[$], g0_cyc[$], s0_cyc[$];  logic [31:0] s0_da[$];
  int g1_who[$], g1_cyc[$], s1_cyc[$];  logic [31:0] s1_da[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    g0_who.delete(); g0_cyc.delete(); s0_cyc.delete(); s0_da.delete();
    g1_who.delete(); g1_cyc.delete(); s1_cyc.delete(); s1_da.delete();
  endtask

  task automatic model_step(input int k, input logic rdy0, input logic rdy1,
                            input logic bsy, input logic wr,
                            input logic [31:0] da, input logic [31:0] db);
    int s;
    bit fp;
    bit e0, e1;
    int g;
    s  = (k == 0) ? SET0 : SET1;
    fp = (k == 0) ? FP0 : FP1;
    e0 = req0_valid;
    e1 = req1_valid && screen;
    g  = -1;
    if (rst_n && !m_busy[k]) begin
      if (e0 && e1)  g = fp ? 0 : (m_last[k] ? 0 : 1);
      else if (e0)   g = 0;
      else if (e1)   g = 1;
    end
    chk($sformatf("ready0[%0d]", k), {31'd0, rdy0}, {31'd0, g == 0});
    chk($sformatf("ready1[%0d]", k), {31'd0, rdy1}, {31'd0, g == 1});
    chk($sformatf("busy[%0d]", k),   {31'd0, bsy},  {31'd0, rst_n && m_busy[k]});
    chk($sformatf("wrreg[%0d]", k),  {31'd0, wr},   {31'd0, m_strb[k] == cyc});
    chk($sformatf("data_a[%0d]", k), da, m_a[k]);
    chk($sformatf("data_b[%0d]", k), db, m_b[k]);
    if (k == 0) begin
      if (rdy0 && req0_valid) begin g0_who.push_back(0); g0_cyc.push_back(cyc); end
      if (rdy1 && req1_valid) begin g0_who.push_back(1); g0_cyc.push_back(cyc); end
      if (wr) begin s0_cyc.push_back(cyc); s0_da.push_back(da); end
    end else begin
      if (rdy0 && req0_valid) begin g1_who.push_back(0); g1_cyc.push_back(cyc); end
      if (rdy1 && req1_valid) begin g1_who.push_back(1); g1_cyc.push_back(cyc); end
      if (wr) begin s1_cyc.push_back(cyc); s1_da.push_back(da); end
    end
    // Advance to the state after the coming edge
    if (!rst_n) begin
      m_busy[k] = 1'b0; m_a[k] = 32'd0; m_b[k] = 32'd0;
      m_last[k] = 1'b1; m_strb[k] = -1;
    end else if (!m_busy[k]) begin
      if (g == 0) begin
        m_busy[k] = 1'b1; m_t[k] = cyc; m_a[k] = r0a; m_b[k] = r0b;
        m_last[k] = 1'b0; m_strb[k] = -1;
      end else if (g == 1) begin
        m_busy[k] = 1'b1; m_t[k] = cyc; m_a[k] = r1a; m_b[k] = r1b;
        m_last[k] = 1'b1; m_strb[k] = -1;
      end
    end else if (m_strb[k] < 0) begin
      // Strobe follows the first cycle at/after the settle time with FIFO not full
      if (cyc >= m_t[k] + s && !wrfull) m_strb[k] = cyc + 1;
    end else if (cyc == m_strb[k] + 1) begin
      m_busy[k] = 1'b0;
    end
  endtask

  // Compare process: every cycle, both instances, on the falling edge
  always @(negedge clk) begin
    model_step(0, bus0.req0_ready, bus0.req1_ready, bus0.busy, bus0.wrreg_export,
               bus0.data_a_export, bus0.data_b_export);
    model_step(1, bus1.req0_ready, bus1.req1_ready, bus1.busy, bus1.wrreg_export,
               bus1.data_a_export, bus1.data_b_export);
    cyc <= cyc + 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_log(input int k, input int want, input int budget);
    int n;
    n = 0;
    while (((k == 0) ? g0_who.size() : g1_who.size()) < want && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (((k == 0) ? g0_who.size() : g1_who.size()) < want) begin
      total++;
      bad++;
      $display("FAIL wait_grant[%0d]: no grant within %0d cycles, need %0d", k, budget, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c0, sc, t, f;

  initial begin
    // Reset
    cycles(2);
    @(negedge clk);
    chk("rst_busy0", {31'd0, bus0.busy}, 32'd0);
    chk("rst_ready0", {31'd0, bus0.req0_ready}, 32'd0);
    chk("rst_data_a0", bus0.data_a_export, 32'd0);
    @(posedge clk); #1;

    // A: single requester-0 transfer
    rst_n = 1'b1; clear_logs();
    r0a = 32'h0000_1234; r0b = 32'h0000_5678; req0_valid = 1'b1;
    c0 = cyc;
    wait_log(0, 1, 5);
    req0_valid = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("A_busy_hold", {31'd0, bus0.busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("A_busy_c4", {31'd0, bus0.busy}, 32'd0);
    cycles(6);
    chk("A_grant_cyc", g0_cyc[0], c0);
    chk("A_lat0", s0_cyc[0] - g0_cyc[0], 32'd2);
    chk("A_nstrobe", s0_cyc.size(), 32'd1);
    chk("A_data", s0_da[0], 32'h0000_1234);
    chk("A_lat1", s1_cyc[0] - g1_cyc[0], 32'd4);

    // B: both requesters continuously, from reset
    rst_n = 1'b0; cycles(2); rst_n = 1'b1; clear_logs();
    r0a = 32'h0000_00A0; r0b = 32'h0000_00A1; req0_valid = 1'b1;
    r1a = 32'h0000_00B0; r1b = 32'h0000_00B1; req1_valid = 1'b1;
    screen = 1'b1;
    cycles(20);
    chk("B_rr_g0", g0_who[0], 32'd0);
    chk("B_rr_g1", g0_who[1], 32'd1);
    chk("B_rr_g2", g0_who[2], 32'd0);
    chk("B_rr_g3", g0_who[3], 32'd1);
    chk("B_space01", s0_cyc[1] - s0_cyc[0], 32'd4);
    chk("B_space12", s0_cyc[2] - s0_cyc[1], 32'd4);
    chk("B_data1", s0_da[1], 32'h0000_00B0);
    chk("B_fp_count", g1_who.size(), 32'd4);
    foreach (g1_who[i]) chk($sformatf("B_fp_g%0d", i), g1_who[i], 32'd0);
    req0_valid = 1'b0;
    g1_who.delete(); g1_cyc.delete();
    wait_log(1, 1, 20);
    chk("B_fp_req1_after_drop", g1_who[0], 32'd1);
    req1_valid = 1'b0; screen = 1'b0;
    cycles(10);

    // C: requester 1 waits for end-of-frame
    clear_logs();
    r1a = 32'h0C0C_0001; r1b = 32'h0C0C_0002; req1_valid = 1'b1;
    cycles(10);
    chk("C_no_grant0", g0_who.size(), 32'd0);
    chk("C_no_grant1", g1_who.size(), 32'd0);
    screen = 1'b1; sc = cyc;
    wait_log(0, 1, 5);
    req1_valid = 1'b0; screen = 1'b0;
    cycles(8);
    chk("C_grant_cyc0", g0_cyc[0], sc);
    chk("C_grant_who0", g0_who[0], 32'd1);
    chk("C_grant_cyc1", g1_cyc[0], sc);
    chk("C_nstrobe0", s0_cyc.size(), 32'd1);
    chk("C_data0", s0_da[0], 32'h0C0C_0001);
    chk("C_nstrobe1", s1_cyc.size(), 32'd1);

    // D: FIFO full during settle
    clear_logs();
    r0a = 32'h0D0D_0001; r0b = 32'h0D0D_0002; req0_valid = 1'b1; wrfull = 1'b1;
    t = cyc;
    wait_log(0, 1, 5);
    req0_valid = 1'b0;
    cycles(5);
    wrfull = 1'b0; f = cyc;
    cycles(8);
    chk("D_grant_cyc", g0_cyc[0], t);
    chk("D_strobe0", s0_cyc[0], f + 1);
    chk("D_strobe1", s1_cyc[0], f + 1);
    chk("D_nstrobe0", s0_cyc.size(), 32'd1);
    chk("D_data0", s0_da[0], 32'h0D0D_0001);

    // E: reset pulse during settle aborts the write and re-arms the tie pointer
    clear_logs();
    r0a = 32'h0E0E_0001; r0b = 32'h0E0E_0002; req0_valid = 1'b1;
    wait_log(0, 1, 5);
    req0_valid = 1'b0; rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1; clear_logs();
    r0a = 32'h0E0E_0003; r0b = 32'h0E0E_0004; req0_valid = 1'b1;
    r1a = 32'h0E0E_0005; r1b = 32'h0E0E_0006; req1_valid = 1'b1; screen = 1'b1;
    @(negedge clk);
    chk("E_data_a0_zero", bus0.data_a_export, 32'd0);
    chk("E_data_b1_zero", bus1.data_b_export, 32'd0);
    @(posedge clk); #1;
    wait_log(0, 1, 5);
    req0_valid = 1'b0; req1_valid = 1'b0; screen = 1'b0;
    chk("E_tie_rr", g0_who[0], 32'd0);
    chk("E_tie_fp", g1_who[0], 32'd0);
    chk("E_no_abort_strobe", s0_cyc.size(), 32'd0);
    cycles(10);
    chk("E_nstrobe0", s0_cyc.size(), 32'd1);
    chk("E_nstrobe1", s1_cyc.size(), 32'd1);
    chk("E_lat1", s1_cyc[0] - g1_cyc[0], 32'd4);
    chk("E_data0", s0_da[0], 32'h0E0E_0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
